// File: rtl/pe_ctx_sequencer_if.sv
// Bundle between the array-level configuration/control side and one PE context
// sequencer: config write port, program start/stall/abort, status pulses and
// the full set of PE register-file/FU control lines.
//   master : configuration/control side (drives cfg_*, start*, stall, abort)
//   slave  : the sequencer (drives status and PE control lines)
interface pe_ctx_sequencer_if #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned LCW   = 8
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic            cfg_we;
    logic [AW-1:0]   cfg_addr;
    logic [59:0]     cfg_data;
    logic            start;
    logic [AW-1:0]   start_pc;
    logic [LCW-1:0]  loop_count;
    logic            stall;
    logic            abort;

    logic            busy;
    logic            done;
    logic            hazard;
    logic            cfg_err;
    logic [AW-1:0]   pc_out;

    logic [8:0]      control_in;
    logic [8:0]      control_out;
    logic [5:0]      control_reg_1;
    logic [5:0]      control_reg_2;
    logic [5:0]      control_put_in;
    logic [5:0]      control_put_out;
    logic [5:0]      control_send;
    logic [3:0]      control_pe2fu_1;
    logic [3:0]      control_pe2fu_2;
    logic            write_back;
    logic            ld;
    logic            ld_write;

    modport master (
        output cfg_we, cfg_addr, cfg_data, start, start_pc, loop_count, stall, abort,
        input  busy, done, hazard, cfg_err, pc_out,
        input  control_in, control_out, control_reg_1, control_reg_2,
               control_put_in, control_put_out, control_send,
               control_pe2fu_1, control_pe2fu_2, write_back, ld, ld_write
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, start, start_pc, loop_count, stall, abort,
        output busy, done, hazard, cfg_err, pc_out,
        output control_in, control_out, control_reg_1, control_reg_2,
               control_put_in, control_put_out, control_send,
               control_pe2fu_1, control_pe2fu_2, write_back, ld, ld_write
    );
endinterface

// File: rtl/pe_ctx_sequencer.sv
// Context sequencer for one PE register-file/FU slice. Holds DEPTH 60-bit
// control words, replays a program of consecutive words (optionally looped)
// on start, and is the sole driver of the PE control lines.
// Ports:
//   CLK, RST_N : clock (rising edge) and asynchronous active-low reset
//   bus        : slave side of pe_ctx_sequencer_if (config, start/stall/abort,
//                status pulses, pc_out and all PE control outputs; all registered)
module pe_ctx_sequencer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned LCW   = 8
) (
    input  logic                CLK,
    input  logic                RST_N,
    pe_ctx_sequencer_if.slave   bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = 60;

    // Idle word: ld=1 keeps the register file from writing, FU operands read 0.
    localparam logic [CW-1:0] NOP_WORD = 60'h2FF_0000_0000_0000;

    typedef struct packed {
        logic       last;
        logic       ld_write;
        logic       ld;
        logic       write_back;
        logic [3:0] pe2fu_2;
        logic [3:0] pe2fu_1;
        logic [5:0] send;
        logic [5:0] put_out;
        logic [5:0] put_in;
        logic [5:0] reg_2;
        logic [5:0] reg_1;
        logic [8:0] ctl_out;
        logic [8:0] ctl_in;
    } ctx_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    ctx_t            mem [DEPTH];

    state_t          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [AW-1:0]   base_q, base_d;
    logic [LCW-1:0]  iter_q, iter_d;

    logic [CW-2:0]   word_q, word_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            hazard_q, hazard_d;
    logic            cfg_err_q, cfg_err_d;

    ctx_t            iss_c;
    logic            hz_c;
    logic            cfg_ok_c;

    assign cfg_ok_c = bus.cfg_we && (state_q == S_IDLE);

    // Context memory: not reset, written only while idle.
    always_ff @(posedge CLK) begin
        if (cfg_ok_c) begin
            mem[bus.cfg_addr] <= ctx_t'(bus.cfg_data);
        end
    end

    // Word at pc with the write-port collision fix: write-back takes the port.
    always_comb begin
        iss_c = mem[pc_q];
        hz_c  = iss_c.write_back && (!iss_c.ld || iss_c.ld_write) &&
                (iss_c.put_in == iss_c.put_out);
        if (hz_c) begin
            iss_c.ld       = 1'b1;
            iss_c.ld_write = 1'b0;
        end
    end

    // State register and program counters.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            base_q  <= '0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            base_q  <= base_d;
            iter_q  <= iter_d;
        end
    end

    // Next-state and program-counter sequencing; abort overrides everything.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        base_d  = base_q;
        iter_d  = iter_q;
        if (bus.abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_d = S_RUN;
                        pc_d    = bus.start_pc;
                        base_d  = bus.start_pc;
                        iter_d  = bus.loop_count;
                    end
                end
                S_RUN: begin
                    if (!bus.stall) begin
                        if (!iss_c.last) begin
                            pc_d = pc_q + AW'(1);
                        end else if (iter_q != '0) begin
                            iter_d = iter_q - LCW'(1);
                            pc_d   = base_q;
                        end else begin
                            state_d = S_DRAIN;
                        end
                    end
                end
                S_DRAIN: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Next values of the registered outputs; NOP unless a word is issued.
    always_comb begin
        word_d    = NOP_WORD[CW-2:0];
        hazard_d  = 1'b0;
        done_d    = 1'b0;
        busy_d    = (state_d != S_IDLE);
        cfg_err_d = bus.cfg_we && (state_q != S_IDLE);
        if (!bus.abort) begin
            case (state_q)
                S_RUN: begin
                    if (!bus.stall) begin
                        word_d   = iss_c[CW-2:0];
                        hazard_d = hz_c;
                    end
                end
                S_DRAIN: done_d = 1'b1;
                default: ;
            endcase
        end
    end

    // Output registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            word_q    <= NOP_WORD[CW-2:0];
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hazard_q  <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            word_q    <= word_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            hazard_q  <= hazard_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.hazard          = hazard_q;
    assign bus.cfg_err         = cfg_err_q;
    assign bus.pc_out          = pc_q;
    assign bus.ld_write        = word_q[58];
    assign bus.ld              = word_q[57];
    assign bus.write_back      = word_q[56];
    assign bus.control_pe2fu_2 = word_q[55:52];
    assign bus.control_pe2fu_1 = word_q[51:48];
    assign bus.control_send    = word_q[47:42];
    assign bus.control_put_out = word_q[41:36];
    assign bus.control_put_in  = word_q[35:30];
    assign bus.control_reg_2   = word_q[29:24];
    assign bus.control_reg_1   = word_q[23:18];
    assign bus.control_out     = word_q[17:9];
    assign bus.control_in      = word_q[8:0];
endmodule

// File: tb/tb_pe_ctx_sequencer.sv
// Self-checking bench for pe_ctx_sequencer. A reference model expands each
// program into its expected issue order (a queue of context addresses) and
// checks every cycle's outputs against it, with stalls and config writes mixed in.
module tb_pe_ctx_sequencer;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned LCW   = 8;
    localparam int unsigned AW    = 4;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic [59:0] mdl [DEPTH];
    logic [59:0] nop;

    pe_ctx_sequencer_if #(.DEPTH(DEPTH), .LCW(LCW)) bus ();

    pe_ctx_sequencer #(.DEPTH(DEPTH), .LCW(LCW)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [58:0] obs_word();
        return {bus.ld_write, bus.ld, bus.write_back, bus.control_pe2fu_2, bus.control_pe2fu_1,
                bus.control_send, bus.control_put_out, bus.control_put_in, bus.control_reg_2,
                bus.control_reg_1, bus.control_out, bus.control_in};
    endfunction

    // Returns {hazard, word as it should appear on the outputs}.
    function automatic logic [59:0] expect_issue(input logic [59:0] w);
        logic [59:0] r;
        logic        hz;
        logic [5:0]  pin;
        logic [5:0]  pout;
        r    = w;
        pin  = w[35:30];
        pout = w[41:36];
        hz   = w[56] && (!w[57] || w[58]) && (pin == pout);
        if (hz) begin
            r[57] = 1'b1;
            r[58] = 1'b0;
        end
        r[59] = hz;
        return r;
    endfunction

    function automatic logic [59:0] rand_word(input bit last);
        logic [59:0] w;
        w = 60'({$urandom, $urandom});
        w[59] = last;
        if ($urandom_range(0, 1) == 1) w[41:36] = w[35:30];
        return w;
    endfunction

    task automatic cfg_write(input int addr, input logic [59:0] data);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = AW'(addr);
        bus.cfg_data = data;
        @(negedge clk);
        bus.cfg_we = 1'b0;
        mdl[addr]  = data;
        chk("cfg_err_idle", 64'(bus.cfg_err), 64'd0);
    endtask

    // Start a program and check every cycle until done has come and gone.
    task automatic run(input int sp, input int lp, input logic [63:0] smask, input bit rnd,
                       input int cfg_at, input bit wr_start, input logic [59:0] wr_word);
        int          ord[$];
        int          a;
        int          idx;
        int          cyc;
        bit          st;
        bit          cfg_now;
        logic [59:0] fx;
        if (wr_start) mdl[sp] = wr_word;
        for (int p = 0; p <= lp; p++) begin
            a = sp;
            for (int n = 0; n < int'(DEPTH); n++) begin
                ord.push_back(a);
                if (mdl[a][59]) break;
                a = (a + 1) % int'(DEPTH);
            end
        end
        bus.start      = 1'b1;
        bus.start_pc   = AW'(sp);
        bus.loop_count = LCW'(lp);
        bus.cfg_we     = wr_start;
        bus.cfg_addr   = AW'(sp);
        bus.cfg_data   = wr_word;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.cfg_we = 1'b0;
        chk("start_busy", 64'(bus.busy), 64'd1);
        chk("start_nop", 64'(obs_word()), 64'(nop[58:0]));
        chk("start_pc", 64'(bus.pc_out), 64'(sp));
        chk("start_cfg_err", 64'(bus.cfg_err), 64'd0);
        idx = 0;
        cyc = 0;
        while (1) begin
            st = ((cyc < 64) ? smask[cyc] : 1'b0) || (rnd && $urandom_range(0, 3) == 0);
            cfg_now      = (cyc == cfg_at);
            bus.stall    = st;
            bus.cfg_we   = cfg_now;
            bus.cfg_addr = AW'($urandom);
            bus.cfg_data = 60'({$urandom, $urandom});
            @(negedge clk);
            bus.stall  = 1'b0;
            bus.cfg_we = 1'b0;
            chk("cfg_err_run", 64'(bus.cfg_err), 64'(cfg_now));
            if (idx < ord.size()) begin
                if (st) begin
                    chk("stall_nop", 64'(obs_word()), 64'(nop[58:0]));
                    chk("stall_hazard", 64'(bus.hazard), 64'd0);
                    chk("stall_pc", 64'(bus.pc_out), 64'(ord[idx]));
                end else begin
                    fx = expect_issue(mdl[ord[idx]]);
                    chk("issue_word", 64'(obs_word()), 64'(fx[58:0]));
                    chk("issue_hazard", 64'(bus.hazard), 64'(fx[59]));
                    idx++;
                    if (idx < ord.size()) chk("issue_pc", 64'(bus.pc_out), 64'(ord[idx]));
                end
                chk("run_busy", 64'(bus.busy), 64'd1);
                chk("run_done", 64'(bus.done), 64'd0);
            end else begin
                chk("drain_nop", 64'(obs_word()), 64'(nop[58:0]));
                chk("drain_done", 64'(bus.done), 64'd1);
                chk("drain_busy", 64'(bus.busy), 64'd0);
                chk("drain_hazard", 64'(bus.hazard), 64'd0);
                break;
            end
            cyc++;
            if (cyc > 2000) begin
                checks++;
                errors++;
                $display("FAIL run_timeout observed=%0d cycles expected<=2000", cyc);
                break;
            end
        end
        @(negedge clk);
        chk("post_done", 64'(bus.done), 64'd0);
        chk("post_busy", 64'(bus.busy), 64'd0);
    endtask

    initial begin
        logic [59:0] w;
        nop        = '0;
        nop[57]    = 1'b1;
        nop[55:48] = 8'hFF;

        rst_n          = 1'b0;
        bus.cfg_we     = 1'b0;
        bus.cfg_addr   = '0;
        bus.cfg_data   = '0;
        bus.start      = 1'b0;
        bus.start_pc   = '0;
        bus.loop_count = '0;
        bus.stall      = 1'b0;
        bus.abort      = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_word", 64'(obs_word()), 64'(nop[58:0]));
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_hazard", 64'(bus.hazard), 64'd0);
        chk("rst_cfg_err", 64'(bus.cfg_err), 64'd0);
        chk("rst_pc", 64'(bus.pc_out), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Memory image: terminators at 1, 4, 8; hazard pair at 7/8.
        for (int i = 0; i < int'(DEPTH); i++) cfg_write(i, rand_word(1'b0));
        cfg_write(1, rand_word(1'b1));
        cfg_write(4, rand_word(1'b1));
        w = rand_word(1'b0);
        w[56] = 1'b1; w[57] = 1'b0; w[35:30] = 6'd5; w[41:36] = 6'd5;
        cfg_write(7, w);
        w[41:36] = 6'd6; w[59] = 1'b1;
        cfg_write(8, w);

        run(2, 0, 64'd0, 1'b0, -1, 1'b0, 60'd0);      // plain 2,3,4
        run(2, 2, 64'd0, 1'b0, -1, 1'b0, 60'd0);      // three passes
        run(2, 0, 64'hC, 1'b0, -1, 1'b0, 60'd0);      // two stalls after ctx3
        run(7, 0, 64'd0, 1'b0, -1, 1'b0, 60'd0);      // hazard / no hazard
        run(15, 0, 64'd0, 1'b0, -1, 1'b0, 60'd0);     // wrap 15,0,1
        run(2, 1, 64'd0, 1'b0, 1, 1'b0, 60'd0);       // rejected write mid-run
        run(2, 0, 64'd0, 1'b0, -1, 1'b0, 60'd0);      // memory unchanged
        run(2, 0, 64'd0, 1'b0, -1, 1'b1, rand_word(1'b0)); // write together with start

        // Abort after three issues: pc is back at 2 for the second pass.
        bus.start = 1'b1; bus.start_pc = AW'(2); bus.loop_count = LCW'(2);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abort_nop", 64'(obs_word()), 64'(nop[58:0]));
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        chk("abort_pc", 64'(bus.pc_out), 64'd2);
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", 64'(bus.done), 64'd0);
        end

        // Reset in the middle of a run.
        bus.start = 1'b1; bus.start_pc = AW'(15); bus.loop_count = LCW'(3);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_word", 64'(obs_word()), 64'(nop[58:0]));
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_pc", 64'(bus.pc_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_busy", 64'(bus.busy), 64'd0);
        chk("postrst_word", 64'(obs_word()), 64'(nop[58:0]));

        run(15, 1, 64'd0, 1'b0, -1, 1'b0, 60'd0);

        // Randomized programs with random stalls.
        repeat (8) begin
            run(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 2)), 64'd0, 1'b1,
                int'($urandom_range(0, 6)), 1'b0, 60'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
